ascii_uart_tx: RTL

Serial output stage for the character generator. It accepts 8-bit ASCII bytes from the upstream character sequencer through a valid/ready interface and buffers them in a small FIFO. Each byte is sent on a single `tx` line as an 8N1 UART frame: start bit, 8 data bits LSB first, stop bit. Bit timing comes from a fixed clock divider, so the sequencer's message ("Guatemala", "QQuetzal", ...) can be observed on a terminal.

---
 rtl/ascii_uart_tx_if.sv | 9 +
 rtl/ascii_uart_tx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ascii_uart_tx_if.sv
// Byte handshake from the character sequencer into the UART transmit stage.
interface ascii_uart_tx_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/ascii_uart_tx.sv
// Buffers ASCII bytes in a small FIFO and shifts each one out on tx as an 8N1 UART frame
// (start bit, 8 data bits LSB first, stop bit), CLKS_PER_BIT clocks per bit.
module ascii_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  ascii_uart_tx_if.slave up,
  input  logic           overflow_clr,
  output logic           tx,
  output logic           busy,
  output logic           overflow
);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             overflow_q;

  logic full, empty, push, pop, baud_tc;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = up.din_valid && !full;
  assign baud_tc = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  assign up.din_ready = !full;
  assign tx           = tx_q;
  assign busy         = (state_q != StIdle) || !empty;
  assign overflow     = overflow_q;

  // Fullness is judged on the pre-edge count, so a pop on the same edge does not rescue a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
      if (up.din_valid && full) begin
        overflow_q <= 1'b1;
      end else if (overflow_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= up.din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_tc) begin
          baud_d = '0;
          // Chain straight into the next start bit so buffered bytes leave with no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end
endmodule
